// File: rtl/wt_pingpong_feeder.sv
// -----------------------------------------------------------------------------
// wt_pingpong_feeder
//
// Double-buffered weight store with a skewed per-column feeder for the systolic
// array. The host fills one bank (fill bank) while the array streams from the
// other (active bank). A commit hands a filled bank to the feeder; finishing a
// tile hands the active bank back to the host. Column c of every tile is
// delayed by c cycles so the weights enter the array on the systolic diagonal.
//
// Optional feature (macro WT_REUSE_EN):
//   adds hold_i / release_i so one bank can serve several tiles before it is
//   released. Without the macro every tile releases its bank at DONE.
//
// Ports:
//   clk            clock
//   rst_n          synchronous active-low reset
//   wr_en_i        host write strobe into the fill bank
//   wr_col_i       target column of the write
//   wr_addr_i      word address within the column
//   wr_data_i      weight word
//   wr_commit_i    pulse: fill bank complete, hand it to the feeder
//   fill_ready_o   fill bank free to accept writes / commit
//   start_i        pulse: feed one tile from the active bank
//   tile_len_i     words per column for this tile (clamped to DEPTH)
//   stall_i        freeze the feed pipeline
//   hold_i         (WT_REUSE_EN) keep the active bank after this tile
//   release_i      (WT_REUSE_EN) drop the active bank while idle
//   w_data_o       per-column weight, column c at [c*DATA_WIDTH +: DATA_WIDTH]
//   w_valid_o      per-column valid
//   busy_o         tile in progress
//   done_o         one-cycle pulse, tile finished
// -----------------------------------------------------------------------------
module wt_pingpong_feeder #(
  parameter int NUM_COL    = 16,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 256,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int COL_WIDTH  = $clog2(NUM_COL)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wr_en_i,
  input  logic [COL_WIDTH-1:0]          wr_col_i,
  input  logic [ADDR_WIDTH-1:0]         wr_addr_i,
  input  logic [DATA_WIDTH-1:0]         wr_data_i,
  input  logic                          wr_commit_i,
  output logic                          fill_ready_o,
  input  logic                          start_i,
  input  logic [ADDR_WIDTH:0]           tile_len_i,
  input  logic                          stall_i,
`ifdef WT_REUSE_EN
  input  logic                          hold_i,
  input  logic                          release_i,
`endif
  output logic [NUM_COL*DATA_WIDTH-1:0] w_data_o,
  output logic [NUM_COL-1:0]            w_valid_o,
  output logic                          busy_o,
  output logic                          done_o
);

  localparam logic [ADDR_WIDTH:0]  LEN_MAX  = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [COL_WIDTH:0]   COL_LIM  = (COL_WIDTH+1)'(NUM_COL);

  typedef enum logic [1:0] {
    IDLE,
    FEED,
    DRAIN,
    DONE
  } state_e;

  // ---------------------------------------------------------------------------
  // Control state
  // ---------------------------------------------------------------------------
  state_e                  state_q, state_d;
  logic [1:0]              bank_valid_q, bank_valid_d;
  logic                    fill_sel_q, fill_sel_d;
  logic                    act_sel_q, act_sel_d;
  logic [ADDR_WIDTH-1:0]   rd_addr_q, rd_addr_d;
  logic [ADDR_WIDTH:0]     len_q, len_d;
  logic [NUM_COL-1:0]      vld_sr_q;     // bit c = valid presented on column c
`ifdef WT_REUSE_EN
  logic                    hold_q, hold_d;
`endif

  logic                    issue;        // read one word per column this cycle
  logic                    release_act;  // hand the active bank back this cycle
  logic                    wr_accept;
  logic                    commit_accept;
  logic [NUM_COL-1:0]      last_only;    // only the last column still valid

  // ---------------------------------------------------------------------------
  // Storage: 2 banks x NUM_COL columns x DEPTH words
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0]   mem_q     [2][NUM_COL][DEPTH];
  logic [DATA_WIDTH-1:0]   rd_data_q [NUM_COL];

  assign fill_ready_o  = !bank_valid_q[fill_sel_q];
  assign busy_o        = (state_q != IDLE);

  // The fill bank is never the active bank while either is in use: if they
  // coincide, either both banks are empty (no feed) or both are full (no fill).
  assign wr_accept     = wr_en_i && fill_ready_o && ({1'b0, wr_col_i} < COL_LIM);
  assign commit_accept = wr_commit_i && fill_ready_o;

  always_comb begin
    last_only              = '0;
    last_only[NUM_COL-1]   = 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Next-state / output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default before any branch, otherwise a missed
    // path would hold its old value and infer a latch.
    state_d      = state_q;
    bank_valid_d = bank_valid_q;
    fill_sel_d   = fill_sel_q;
    act_sel_d    = act_sel_q;
    rd_addr_d    = rd_addr_q;
    len_d        = len_q;
`ifdef WT_REUSE_EN
    hold_d       = hold_q;
`endif
    issue        = 1'b0;
    release_act  = 1'b0;
    done_o       = 1'b0;

    // Host side runs regardless of stall.
    if (commit_accept) begin
      bank_valid_d[fill_sel_q] = 1'b1;
      fill_sel_d               = ~fill_sel_q;
    end

    // A stall freezes the whole feed side, including a pending done pulse.
    if (!stall_i) begin
      case (state_q)
        IDLE: begin
          if (start_i && bank_valid_q[act_sel_q] && (tile_len_i != '0)) begin
            state_d   = FEED;
            rd_addr_d = '0;
            len_d     = (tile_len_i > LEN_MAX) ? LEN_MAX : tile_len_i;
`ifdef WT_REUSE_EN
            hold_d    = hold_i;
`endif
          end
`ifdef WT_REUSE_EN
          // A start in the same cycle wins; the release is then ignored.
          else if (release_i && bank_valid_q[act_sel_q]) begin
            release_act = 1'b1;
          end
`endif
        end

        FEED: begin
          issue     = 1'b1;
          rd_addr_d = rd_addr_q + 1'b1;
          if ({1'b0, rd_addr_q} == (len_q - 1'b1)) begin
            state_d = DRAIN;
          end
        end

        // Words leave the pipeline as one contiguous burst, so the tail has
        // reached the last column exactly when it is the only bit left.
        DRAIN: begin
          if (vld_sr_q == last_only) begin
            state_d = DONE;
          end
        end

        DONE: begin
          done_o  = 1'b1;
          state_d = IDLE;
`ifdef WT_REUSE_EN
          release_act = !hold_q;
`else
          release_act = 1'b1;
`endif
        end

        default: state_d = IDLE;
      endcase
    end

    // Commit targets the fill bank, release the active bank: never the same
    // bank when both fire, so both updates apply.
    if (release_act) begin
      bank_valid_d[act_sel_q] = 1'b0;
      act_sel_d               = ~act_sel_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Control registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!rst_n) begin
      state_q      <= IDLE;
      bank_valid_q <= 2'b00;
      fill_sel_q   <= 1'b0;
      act_sel_q    <= 1'b0;
      rd_addr_q    <= '0;
      len_q        <= '0;
      vld_sr_q     <= '0;
`ifdef WT_REUSE_EN
      hold_q       <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      bank_valid_q <= bank_valid_d;
      fill_sel_q   <= fill_sel_d;
      act_sel_q    <= act_sel_d;
      rd_addr_q    <= rd_addr_d;
      len_q        <= len_d;
`ifdef WT_REUSE_EN
      hold_q       <= hold_d;
`endif
      if (!stall_i) begin
        vld_sr_q[0] <= issue;
        for (int i = 1; i < NUM_COL; i++) begin
          vld_sr_q[i] <= vld_sr_q[i-1];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Weight memory and registered read port
  // ---------------------------------------------------------------------------
  // NOTE: storage and data pipeline carry no reset; validity lives in
  // bank_valid_q / vld_sr_q, and unreset arrays map onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem_q[fill_sel_q][wr_col_i][wr_addr_i] <= wr_data_i;
    end
    if (issue) begin
      for (int c = 0; c < NUM_COL; c++) begin
        rd_data_q[c] <= mem_q[act_sel_q][c][rd_addr_q];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Skew pipeline: column c delays its read data by c cycles
  // ---------------------------------------------------------------------------
  for (genvar c = 0; c < NUM_COL; c++) begin : g_col
    logic [DATA_WIDTH-1:0] col_data;

    if (c == 0) begin : g_nodly
      assign col_data = rd_data_q[0];
    end else begin : g_dly
      logic [DATA_WIDTH-1:0] dly_q [c];

      always_ff @(posedge clk) begin
        if (!stall_i) begin
          dly_q[0] <= rd_data_q[c];
          for (int s = 1; s < c; s++) begin
            dly_q[s] <= dly_q[s-1];
          end
        end
      end

      assign col_data = dly_q[c-1];
    end

    assign w_valid_o[c]                           = vld_sr_q[c];
    assign w_data_o[c*DATA_WIDTH +: DATA_WIDTH]   = vld_sr_q[c] ? col_data : '0;
  end

endmodule

// File: tb/tb_wt_pingpong_feeder.sv
// -----------------------------------------------------------------------------
// tb_wt_pingpong_feeder
//
// Self-checking bench for wt_pingpong_feeder. A small reference model tracks
// bank ownership and the written weights; starting a tile pushes every
// expected (word, cycle) per column into a scoreboard, and a negedge monitor
// pops and compares as the lanes present data.
// -----------------------------------------------------------------------------
module tb_wt_pingpong_feeder;

  localparam int NC    = 16;
  localparam int DW    = 8;
  localparam int DEPTH = 256;
  localparam int AW    = 8;
  localparam int CW    = 4;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               wr_en_i;
  logic [CW-1:0]      wr_col_i;
  logic [AW-1:0]      wr_addr_i;
  logic [DW-1:0]      wr_data_i;
  logic               wr_commit_i;
  logic               fill_ready_o;
  logic               start_i;
  logic [AW:0]        tile_len_i;
  logic               stall_i;
`ifdef WT_REUSE_EN
  logic               hold_i;
  logic               release_i;
`endif
  logic [NC*DW-1:0]   w_data_o;
  logic [NC-1:0]      w_valid_o;
  logic               busy_o;
  logic               done_o;

  always #5 clk = ~clk;

  wt_pingpong_feeder #(
    .NUM_COL    (NC),
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_en_i      (wr_en_i),
    .wr_col_i     (wr_col_i),
    .wr_addr_i    (wr_addr_i),
    .wr_data_i    (wr_data_i),
    .wr_commit_i  (wr_commit_i),
    .fill_ready_o (fill_ready_o),
    .start_i      (start_i),
    .tile_len_i   (tile_len_i),
    .stall_i      (stall_i),
`ifdef WT_REUSE_EN
    .hold_i       (hold_i),
    .release_i    (release_i),
`endif
    .w_data_o     (w_data_o),
    .w_valid_o    (w_valid_o),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  // ---------------------------------------------------------------------------
  // Bookkeeping
  // ---------------------------------------------------------------------------
  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int stall_cnt   = 0;
  int stall_base  = 0;
  int t0          = 0;
  int exp_done    = 0;
  bit mon_en      = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (stall_i) stall_cnt <= stall_cnt + 1;

  // Reference model of bank ownership and contents
  logic [DW-1:0] shadow [2][NC][DEPTH];
  bit            m_valid [2];
  bit            m_fill;
  bit            m_act;
  bit            m_busy;
  bit            m_hold;

  // Scoreboard: expected word and presentation cycle per column
  logic [DW-1:0] exp_d [NC][$];
  int            exp_c [NC][$];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Output monitor
  // ---------------------------------------------------------------------------
  logic [NC-1:0]    prev_valid;
  logic [NC*DW-1:0] prev_data;
  bit               stall_prev = 0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (stall_prev) begin
        check("stall_hold_valid", w_valid_o, prev_valid);
        check("stall_hold_data", w_data_o, prev_data);
      end else begin
        for (int c = 0; c < NC; c++) begin
          if (w_valid_o[c]) begin
            if (exp_d[c].size() == 0) begin
              check($sformatf("lane%0d_spurious_valid", c), w_valid_o[c], 1'b0);
            end else begin
              logic [DW-1:0] d;
              int            t;
              d = exp_d[c].pop_front();
              t = exp_c[c].pop_front();
              check($sformatf("lane%0d_data", c), w_data_o[c*DW +: DW], d);
              check($sformatf("lane%0d_cycle", c), cyc, t + (stall_cnt - stall_base));
            end
          end else begin
            check($sformatf("lane%0d_idle_zero", c), w_data_o[c*DW +: DW], '0);
          end
        end
      end
    end
    prev_valid = w_valid_o;
    prev_data  = w_data_o;
    stall_prev = stall_i;
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_valid[0] = 0;
    m_valid[1] = 0;
    m_fill     = 0;
    m_act      = 0;
    m_busy     = 0;
    m_hold     = 0;
    for (int c = 0; c < NC; c++) begin
      exp_d[c].delete();
      exp_c[c].delete();
    end
  endtask

  task automatic wr(input int col, input int addr, input int data);
    if (!m_valid[m_fill]) shadow[m_fill][col][addr] = DW'(data);
    wr_en_i   = 1'b1;
    wr_col_i  = CW'(col);
    wr_addr_i = AW'(addr);
    wr_data_i = DW'(data);
    tick();
    wr_en_i   = 1'b0;
  endtask

  task automatic fill(input int n, input int seed);
    for (int c = 0; c < NC; c++)
      for (int k = 0; k < n; k++)
        wr(c, k, seed + c * 16 + k);
  endtask

  task automatic commit();
    if (!m_valid[m_fill]) begin
      m_valid[m_fill] = 1;
      m_fill          = ~m_fill;
    end
    wr_commit_i = 1'b1;
    tick();
    wr_commit_i = 1'b0;
  endtask

  task automatic start(input int len, input bit hold);
    bit acc;
    int n;
    acc = !m_busy && m_valid[m_act] && (len != 0);
    if (acc) begin
      n          = (len > DEPTH) ? DEPTH : len;
      t0         = cyc;
      stall_base = stall_cnt;
      for (int c = 0; c < NC; c++) begin
        for (int k = 0; k < n; k++) begin
          exp_d[c].push_back(shadow[m_act][c][k]);
          exp_c[c].push_back(t0 + 2 + k + c);
        end
      end
      exp_done = t0 + 2 + (n - 1) + (NC - 1) + 1;
      m_busy   = 1;
      m_hold   = hold;
    end
    tile_len_i = (AW+1)'(len);
    start_i    = 1'b1;
`ifdef WT_REUSE_EN
    hold_i     = hold;
`endif
    tick();
    start_i    = 1'b0;
`ifdef WT_REUSE_EN
    hold_i     = 1'b0;
`endif
    check("busy_after_start", busy_o, m_busy);
  endtask

  task automatic wait_done(input int budget);
    bit seen;
    seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (done_o === 1'b1) seen = 1;
    end
    check("done_seen", seen, 1'b1);
    if (seen) check("done_cycle", cyc, exp_done + (stall_cnt - stall_base));
    @(posedge clk);
    #1;
    if (!m_hold) begin
      m_valid[m_act] = 0;
      m_act          = ~m_act;
    end
    m_busy = 0;
    check("done_one_cycle", done_o, 1'b0);
    check("busy_after_done", busy_o, 1'b0);
    for (int c = 0; c < NC; c++) check($sformatf("lane%0d_drained", c), exp_d[c].size(), 0);
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    rst_n       = 1'b0;
    wr_en_i     = 1'b0;
    wr_col_i    = '0;
    wr_addr_i   = '0;
    wr_data_i   = '0;
    wr_commit_i = 1'b0;
    start_i     = 1'b0;
    tile_len_i  = '0;
    stall_i     = 1'b0;
`ifdef WT_REUSE_EN
    hold_i      = 1'b0;
    release_i   = 1'b0;
`endif
    model_reset();
    repeat (2) tick();

    // Reset state
    check("rst_busy", busy_o, 1'b0);
    check("rst_done", done_o, 1'b0);
    check("rst_valid", w_valid_o, '0);
    check("rst_data", w_data_o, '0);
    check("rst_fill_ready", fill_ready_o, 1'b1);
    rst_n  = 1'b1;
    mon_en = 1;
    tick();

    // Basic tile: col*16+addr, len 4, done at T0+21
    fill(4, 0);
    commit();
    check("fill_ready_other_free", fill_ready_o, 1'b1);
    start(4, 0);
    start(4, 0);  // ignored while busy
    check("fill_ready_during_tile", fill_ready_o, 1'b1);
    wait_done(200);

    // Both banks full: writes and commit dropped
    fill(4, 8'h40);
    commit();
    fill(4, 8'h80);
    commit();
    check("both_full_fill_ready", fill_ready_o, 1'b0);
    for (int c = 0; c < NC; c += 5) wr(c, 1, 8'hFF);
    commit();
    check("both_full_still_blocked", fill_ready_o, 1'b0);
    start(4, 0);
    wait_done(200);
    check("fill_ready_after_release", fill_ready_o, 1'b1);
    start(4, 0);
    wait_done(200);

    // Stall for 3 cycles at T0+5 during a len-8 tile
    fill(8, 8'h23);
    commit();
    start(8, 0);
    repeat (4) tick();
    stall_i = 1'b1;
    repeat (3) tick();
    stall_i = 1'b0;
    wait_done(200);

    // Ignored starts: no valid bank, then zero length
    start(4, 0);
    repeat (5) tick();
    check("no_bank_busy", busy_o, 1'b0);
    check("no_bank_valid", w_valid_o, '0);
    fill(DEPTH, 8'h05);
    commit();
    start(0, 0);
    repeat (5) tick();
    check("len0_busy", busy_o, 1'b0);
    check("len0_valid", w_valid_o, '0);

    // Over-long tile clamps to DEPTH words
    start(300, 0);
    wait_done(600);

    // Reset mid-tile at T0+6
    fill(8, 8'h11);
    commit();
    start(8, 0);
    repeat (5) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    model_reset();
    check("midrst_valid", w_valid_o, '0);
    check("midrst_busy", busy_o, 1'b0);
    check("midrst_fill_ready", fill_ready_o, 1'b1);
    start(4, 0);
    repeat (3) tick();
    check("midrst_start_ignored", busy_o, 1'b0);

`ifdef WT_REUSE_EN
    // Reuse: two held tiles from the same bank, then release
    fill(4, 8'h61);
    commit();
    start(4, 1);
    wait_done(200);
    start(4, 1);
    wait_done(200);
    release_i = 1'b1;
    m_valid[m_act] = 0;
    m_act          = ~m_act;
    tick();
    release_i = 1'b0;
    start(4, 0);
    repeat (3) tick();
    check("release_start_ignored", busy_o, 1'b0);
    fill(4, 8'h72);
    commit();
    start(4, 0);
    wait_done(200);
`endif

    repeat (5) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/wt_pingpong_feeder.md
Name: wt_pingpong_feeder

Overview:
- Parametrised, double-buffered weight store and skewed feeder for the systolic-array datapath; successor to the single-bank weight buffer and BRAM pair.
- The host fills one bank (fill bank) while the array is fed from the other (active bank). Banks swap by commit/done handshakes.
- Each tile streams `tile_len` words per column. Column c is delayed by c cycles to form the systolic diagonal.
- Sits between the AXI/host weight write path and the SA weight inputs.

Parameters:
- NUM_COL, 16, number of SA columns (weight lanes)
- DATA_WIDTH, 8, weight word width
- DEPTH, 256, words per column per bank
- ADDR_WIDTH, $clog2(DEPTH), word address width
- COL_WIDTH, $clog2(NUM_COL), column select width

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; synchronous, active-low
- wr_en_i  in  1  host write strobe into fill bank
- wr_col_i  in  COL_WIDTH  target column
- wr_addr_i  in  ADDR_WIDTH  word address within column
- wr_data_i  in  DATA_WIDTH  weight word
- wr_commit_i  in  1  pulse: fill bank complete, hand to feeder
- fill_ready_o  out  1  fill bank free to accept writes/commit
- start_i  in  1  pulse: feed one tile from active bank
- tile_len_i  in  ADDR_WIDTH+1  words per column for this tile
- stall_i  in  1  freeze feed pipeline
- w_data_o  out  DATA_WIDTH x [NUM_COL]  per-column weight
- w_valid_o  out  1 x [NUM_COL]  per-column valid
- busy_o  out  1  tile in progress
- done_o  out  1  one-cycle pulse, tile finished

Behaviour:
- Reset (rst_n=0 at posedge): FSM=IDLE, bank_valid=2'b00, fill_sel=act_sel=0, all w_valid_o/w_data_o=0, busy_o=0, done_o=0. fill_ready_o=1 the cycle after reset. Reset mid-tile aborts the tile and discards both banks.
- Storage: 2 banks x NUM_COL x DEPTH words. Reads are synchronous with 1-cycle latency. Write and read never target the same bank.
- fill_ready_o = !bank_valid[fill_sel] (combinational from state).
- Write: if wr_en_i && fill_ready_o, write mem[fill_sel][wr_col_i][wr_addr_i]. Writes with fill_ready_o=0 are dropped. wr_col_i>=NUM_COL is dropped.
- Commit: if wr_commit_i && fill_ready_o, then bank_valid[fill_sel]<=1 and fill_sel<=~fill_sel. A commit with fill_ready_o=0 is ignored. wr_en_i in the same cycle as a commit still writes to the old fill bank.
- FSM states: IDLE, FEED, DRAIN, DONE.
- IDLE: start_i is accepted only if bank_valid[act_sel]=1 and tile_len_i!=0. Otherwise it is ignored. On accept: latch len=min(tile_len_i,DEPTH), rd_addr=0, busy_o=1, go to FEED.
- FEED: issues one read per unstalled cycle at rd_addr, rd_addr++. After issuing rd_addr=len-1, go to DRAIN.
- Timing: start accepted at cycle T0. Column c word k is presented with w_valid_o[c]=1 at cycle T0+2+k+c, with no stalls.
- DRAIN: waits until the skew pipeline is empty, i.e. the last valid of column NUM_COL-1 has been presented. Then go to DONE.
- DONE: done_o=1 for exactly one cycle, then bank_valid[act_sel]<=0, act_sel<=~act_sel, busy_o<=0, go to IDLE.
  - A commit in the same cycle as the release is applied too; both bank updates take effect.
- stall_i=1 freezes rd_addr, the FSM, and the skew pipeline. w_data_o/w_valid_o hold their values. done_o is not asserted while stalled, and is deferred until stall_i drops.
- When w_valid_o[c]=0, w_data_o[c] is driven to 0.
- start_i while busy_o=1 is ignored (no queuing).
- Skew pipeline per column is a shift register of length c, built from the registered read data. Column 0 has no extra delay.

Optional Feature:
- Macro: WT_REUSE_EN.
- Defined: adds input hold_i (1 bit), sampled with start_i. If it was 1, DONE does not clear bank_valid or toggle act_sel; the same weights serve the next tile (conv reuse across bursts). Adds input release_i: in IDLE it clears bank_valid[act_sel] and toggles act_sel. release_i is ignored when busy or when the active bank is invalid.
- Undefined: neither port exists; every tile releases its bank at DONE.

Test Plan:
- Reset, write col 0..15 addr 0..3 with value col*16+addr, commit, start len=4 → column c emits c*16+0..3 on cycles T0+2+c..T0+5+c. done_o at T0+2+3+15+1=T0+21. fill_ready_o=1 throughout (other bank free).
- Commit bank 0, commit bank 1 → fill_ready_o=0. Writes now dropped (readback unchanged). Start/complete tile → fill_ready_o=1 the cycle after done_o, fill_sel=0.
- stall_i high 3 cycles at T0+5 with len=8 → all lanes hold value/valid during stall. Sequence resumes unchanged. done_o is 3 cycles later than unstalled.
- start_i with no valid bank, or tile_len_i=0 → busy_o stays 0, no w_valid_o. tile_len_i=300 → 256 words per column.
- rst_n=0 at T0+6 mid-tile → next cycle all w_valid_o=0, busy_o=0, fill_ready_o=1. A subsequent start_i is ignored until a new commit.
- WT_REUSE_EN: start with hold_i=1 twice → identical data both tiles. release_i → next start ignored until commit.
